max_pooler: RTL and testbench



---
 rtl/max_pooler_pkg.sv | 23 ++
 rtl/max_pool_rowbuf.sv | 47 ++++
 rtl/max_pooler.sv | 107 ++++++++++
 tb/tb_max_pooler.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/max_pooler_pkg.sv
// Shared configuration and helpers for the max_pooler stage: default geometry,
// derived output dimensions, counter widths and the signed max function.
package max_pooler_pkg;

   localparam int FM_ROW_DEF = 12;
   localparam int FM_COL_DEF = 12;
   localparam int P_DEF      = 4;
   localparam int N_DATA_DEF = 32;

   localparam int OUT_COLS = FM_COL_DEF / P_DEF;
   localparam int OUT_ROWS = FM_ROW_DEF / P_DEF;

   // Counters are split into in-window phase and window index, so no divider is needed
   localparam int PH_W = $clog2(P_DEF);
   localparam int OC_W = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
   localparam int OR_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

   function automatic logic [N_DATA_DEF-1:0] smax(input logic [N_DATA_DEF-1:0] a,
                                                  input logic [N_DATA_DEF-1:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

endpackage

// File: rtl/max_pool_rowbuf.sv
// Partial-max row buffer: one entry per output column, combinational read,
// read-modify-write merge of a completed horizontal group maximum.
module max_pool_rowbuf
   import max_pooler_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [OC_W-1:0]       idx_i,
   input  logic                  init_i,
   input  logic                  upd_i,
   input  logic [N_DATA_DEF-1:0] h_i,
   output logic [N_DATA_DEF-1:0] merged_o
);

   logic [N_DATA_DEF-1:0] entry_arr [OUT_COLS];
   logic                  valid_arr [OUT_COLS];

   genvar gi;
   generate
      for (gi = 0; gi < OUT_COLS; gi++) begin : g_ent
         logic                  valid_q;
         logic [N_DATA_DEF-1:0] entry_q;
         logic                  hit;

         assign hit = upd_i && (idx_i == OC_W'(gi));

         always_ff @(posedge clk) begin
            if (rst)
               valid_q <= 1'b0;
            else if (hit)
               valid_q <= 1'b1;
         end

         always_ff @(posedge clk) begin
            if (hit)
               entry_q <= merged_o;
         end

         assign entry_arr[gi] = entry_q;
         assign valid_arr[gi] = valid_q;
      end
   endgenerate

   // An invalidated entry behaves like the first row of a window: overwrite
   assign merged_o = (init_i || !valid_arr[idx_i]) ? h_i : smax(entry_arr[idx_i], h_i);

endmodule

// File: rtl/max_pooler.sv
// Streaming non-overlapping P x P max-pooling stage with end-of-frame flag.
// Optional MAXPOOL_RELU_EN clamps negative pooled outputs to zero.
module max_pooler
   import max_pooler_pkg::*;
#(
   parameter int FM_ROW = FM_ROW_DEF,
   parameter int FM_COL = FM_COL_DEF,
   parameter int P      = P_DEF,
   parameter int N_DATA = N_DATA_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_in_vld,
   input  logic [N_DATA-1:0] data_in,
   output logic [N_DATA-1:0] data_out,
   output logic              data_out_vld,
   output logic              data_out_end
);

   generate
      if ((FM_ROW % P) != 0 || (FM_COL % P) != 0) begin : g_bad_geom
         $fatal(1, "max_pooler: FM_ROW and FM_COL must be multiples of P");
      end
      // Derived widths and the max helper live in the package
      if (FM_ROW != FM_ROW_DEF || FM_COL != FM_COL_DEF || P != P_DEF || N_DATA != N_DATA_DEF
          || P < 2) begin : g_bad_cfg
         $fatal(1, "max_pooler: parameters must match max_pooler_pkg and P >= 2");
      end
   endgenerate

   logic [PH_W-1:0]   col_ph_q, row_ph_q;
   logic [OC_W-1:0]   col_grp_q;
   logic [OR_W-1:0]   row_grp_q;
   logic [N_DATA-1:0] hmax_q, h, merged, data_out_d, data_out_q;
   logic              data_out_vld_q, data_out_end_q;
   logic              last_h, last_v, last_cg, last_rg, win_done;

   assign last_h   = (col_ph_q  == PH_W'(P - 1));
   assign last_v   = (row_ph_q  == PH_W'(P - 1));
   assign last_cg  = (col_grp_q == OC_W'(OUT_COLS - 1));
   assign last_rg  = (row_grp_q == OR_W'(OUT_ROWS - 1));
   assign h        = smax(hmax_q, data_in);
   assign win_done = data_in_vld && last_h && last_v;

   max_pool_rowbuf u_rowbuf (
      .clk      (clk),
      .rst      (rst),
      .idx_i    (col_grp_q),
      .init_i   (row_ph_q == '0),
      .upd_i    (data_in_vld && last_h),
      .h_i      (h),
      .merged_o (merged)
   );

   always_comb begin
      data_out_d = merged;
`ifdef MAXPOOL_RELU_EN
      if (merged[N_DATA-1])
         data_out_d = '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_ph_q       <= '0;
         col_grp_q      <= '0;
         row_ph_q       <= '0;
         row_grp_q      <= '0;
         hmax_q         <= '0;
         data_out_q     <= '0;
         data_out_vld_q <= 1'b0;
         data_out_end_q <= 1'b0;
      end else begin
         data_out_vld_q <= 1'b0;
         data_out_end_q <= 1'b0;
         if (data_in_vld) begin
            hmax_q <= (col_ph_q == '0) ? data_in : h;
            if (last_h) begin
               col_ph_q <= '0;
               if (last_cg) begin
                  col_grp_q <= '0;
                  if (last_v) begin
                     row_ph_q  <= '0;
                     row_grp_q <= last_rg ? '0 : row_grp_q + 1'b1;
                  end else begin
                     row_ph_q <= row_ph_q + 1'b1;
                  end
               end else begin
                  col_grp_q <= col_grp_q + 1'b1;
               end
            end else begin
               col_ph_q <= col_ph_q + 1'b1;
            end
            if (win_done) begin
               data_out_q     <= data_out_d;
               data_out_vld_q <= 1'b1;
               data_out_end_q <= last_cg && last_rg;
            end
         end
      end
   end

   assign data_out     = data_out_q;
   assign data_out_vld = data_out_vld_q;
   assign data_out_end = data_out_end_q;

endmodule

// File: tb/tb_max_pooler.sv
// Scoreboard bench for max_pooler: stimulus pushes hand-computed expected outputs,
// a negedge monitor pops and checks value, end flag and arrival cycle.
module tb_max_pooler;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         data_in_vld = 1'b0;
   logic [N-1:0] data_in = '0;
   logic [N-1:0] data_out;
   logic         data_out_vld;
   logic         data_out_end;

   max_pooler dut (
      .clk          (clk),
      .rst          (rst),
      .data_in_vld  (data_in_vld),
      .data_in      (data_in),
      .data_out     (data_out),
      .data_out_vld (data_out_vld),
      .data_out_end (data_out_end)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [N-1:0] val;
      bit           e;
      int           cyc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Hand-computed window maxima in output order: ramp, -5/+3 frame, 1000-at-origin
`ifdef MAXPOOL_RELU_EN
   int exp_tab [3][9] = '{'{40, 44, 48, 88, 92, 96, 136, 140, 144},
                          '{0, 0, 0, 0, 0, 3, 0, 0, 0},
                          '{1000, 0, 0, 0, 0, 0, 0, 0, 0}};
`else
   int exp_tab [3][9] = '{'{40, 44, 48, 88, 92, 96, 136, 140, 144},
                          '{-5, -5, -5, -5, -5, 3, -5, -5, -5},
                          '{1000, 0, 0, 0, 0, 0, 0, 0, 0}};
`endif

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                  name, $signed(act), act, $signed(req), req);
      end
   endtask

   function automatic int pix(input int kind, input int r, input int c);
      case (kind)
         0:       return r * 12 + c + 1;
         1:       return (r == 5 && c == 9) ? 3 : -5;
         default: return (r == 0 && c == 0) ? 1000 : 0;
      endcase
   endfunction

   // Monitor: one line per output pulse, compared against the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (data_out_vld) begin
         $display("[TB] out cyc=%0d data=%0d end=%0b", cyc, $signed(data_out), data_out_end);
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL extra_pulse: got data=%0d at cyc %0d, expected no output",
                     $signed(data_out), cyc);
         end else begin
            e = q.pop_front();
            check("data_out", data_out, e.val);
            check("data_out_end", N'(data_out_end), N'(e.e));
            check("latency_cycle", N'(cyc), N'(e.cyc));
         end
      end else if (data_out_end) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL end_without_vld: got end=1 vld=0 at cyc %0d, expected end=0", cyc);
      end
   end

   task automatic run_frame(input int kind, input bit gaps, input int npix);
      exp_t e;
      for (int idx = 0; idx < npix; idx++) begin
         int r = idx / 12;
         int c = idx % 12;
         if (gaps && $urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               @(negedge clk);
               data_in_vld = 1'b0;
               data_in     = 32'h7fff_ffff;
            end
         end
         @(negedge clk);
         data_in_vld = 1'b1;
         data_in     = N'(pix(kind, r, c));
         if (r % 4 == 3 && c % 4 == 3) begin
            e.val = N'(exp_tab[kind][(r / 4) * 3 + c / 4]);
            e.e   = (r == 11 && c == 11);
            e.cyc = cyc + 1;
            q.push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         data_in_vld = 1'b0;
         data_in     = '0;
      end
   endtask

   task automatic check_reset(input string tag);
      $display("[TB] reset check %s", tag);
      check({tag, "_data_out"}, data_out, '0);
      check({tag, "_data_out_vld"}, N'(data_out_vld), '0);
      check({tag, "_data_out_end"}, N'(data_out_end), '0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset("init");
      rst = 1'b0;

      run_frame(0, 1'b0, 144);   // ramp
      idle(5);
      run_frame(1, 1'b0, 144);   // negative / mixed
      idle(5);
      run_frame(2, 1'b0, 144);   // max at window's first pixel
      idle(5);
      run_frame(0, 1'b1, 144);   // gapped ramp
      idle(5);

      run_frame(0, 1'b0, 70);    // partial frame, then reset
      @(negedge clk);
      data_in_vld = 1'b0;
      rst         = 1'b1;
      repeat (2) @(negedge clk);
      check_reset("mid_frame");
      rst = 1'b0;
      run_frame(0, 1'b0, 144);
      idle(5);

      run_frame(0, 1'b0, 144);   // back-to-back frames
      run_frame(0, 1'b0, 144);
      idle(5);

      check("leftover_expected", N'(q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: simulation did not complete, expected completion before 2 ms");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "timeout");
   end

endmodule
